pipelined_arith_acc: RTL and testbench
======================================

# pipelined_arith_acc

Parametrised, two-stage pipelined arithmetic unit for the Tiny Tapeout user design. It generalises the plain 8-bit combinational adder to:
- configurable operand width;
- four operations: add, subtract, accumulate, clear;
- carry and signed-overflow flags;
- valid/ready flow control on input and output;
- a persistent accumulator.

It sits between the pin-mapping top level and the dedicated/bidirectional IO buses.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous and active-low
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit accepts beat this cycle
- op  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored by ACC/CLR)
- out_valid  output  1  result beat available
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  operation result
- carry  output  1  unsigned carry-out (ADD/ACC) or borrow (SUB)
- overflow  output  1  two's-complement overflow
- acc_out  output  WIDTH  current accumulator value

## Operation

- Beat accepted when in_valid && in_ready. Stage 1 registers op, a, b; stage 2 computes and registers result, carry, overflow.
- ADD: {carry,result} = a + b (WIDTH+1 bits). Overflow = sign(a)==sign(b) && sign(result)!=sign(a).
- SUB: result = a − b mod 2^WIDTH; carry = (a < b unsigned). Overflow = sign(a)!=sign(b) && sign(result)!=sign(a).
- ACC: as ADD with operands acc, a. The accumulator loads the result on the same edge that stage 2 loads.
- CLR: result = 0, carry = 0, overflow = 0. Accumulator loads 0.
- The accumulator is read and written only in stage 2. Back-to-back ACC beats therefore chain correctly with no bubbles.
- ADD/SUB never modify the accumulator.

Flow control:
- s2_adv = !out_valid || out_ready.
- in_ready = rst_n && (!s1_valid || s2_adv).
- Stage 1 advances into stage 2 when s1_valid && s2_adv.
- Stage 1 reloads when a beat is accepted and empties when it advances without a new beat.
- While out_valid && !out_ready, result, carry, overflow and acc_out hold stable, and stage 2 does not change.
- No beat is dropped or duplicated. Output order equals acceptance order.

## Timing

- Reset (rst_n low at a rising edge): out_valid=0, result=0, carry=0, overflow=0, acc_out=0, stage 1 empty. in_ready=0 while rst_n low, 1 on the first cycle after release.
- Reset mid-operation discards all in-flight beats and clears the accumulator. It takes priority over every other event in that cycle.
- Latency: beat accepted at edge k produces out_valid=1 after edge k+1. Input presented in cycle 0 appears at the output in cycle 2.
- Throughput: one beat per cycle when out_ready is held high.
- Capacity under backpressure: two beats (stage 1 + stage 2). in_ready is combinational from out_ready and drops the cycle both stages are full and out_ready=0.
- Simultaneous pop and push when full: stage 2 takes stage 1's beat, stage 1 takes the new beat, and out_valid stays 1.
- in_valid may drop at any time with no effect on beats already accepted.

## Configuration

- SATURATE_EN defined:
  - ADD/ACC results with carry=1 clamp to 2^WIDTH−1.
  - SUB results with carry=1 (borrow) clamp to 0.
  - The accumulator stores the clamped value.
  - carry and overflow flags are still reported from the unclamped computation.
- SATURATE_EN undefined: all arithmetic wraps modulo 2^WIDTH and no clamp logic is synthesised.

## Test plan

All scenarios use WIDTH=8 and out_ready=1 unless noted.

- ADD a=200 b=100 → result=44, carry=1, overflow=0 (SATURATE_EN: result=255). Out_valid is seen 2 cycles after in_valid.
- ADD a=100 b=100 → result=200, carry=0, overflow=1. SUB a=5 b=10 → result=251, carry=1, overflow=0 (SATURATE_EN: 0).
- CLR then ACC a=10, 20, 30 on consecutive cycles → results 0,10,30,60 on consecutive cycles. acc_out=60 afterwards, and no bubbles occur.
- Backpressure: out_ready=0, offer ADD beats 1+1, 2+2, 3+3 → two accepted, and in_ready=0 while the third is held. Raise out_ready → results 2,4,6 in order, each exactly once.
- Reset mid-operation: pipeline full with ACC a=5 beats, acc=40. rst_n low one cycle → out_valid=0, acc_out=0, all outputs 0, and in_ready=1 the cycle after release.
- Random regression: 10k random ops with random in_valid/out_ready against a reference model → bit-exact results, flags, and ordering.

Source files
------------

// File: rtl/pipelined_arith_acc_if.sv
// Operand and result handshake bundle for pipelined_arith_acc.
// The slave modport is the arithmetic unit; the master modport is whoever drives it.
`timescale 1ns/1ps
interface pipelined_arith_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic [WIDTH-1:0] acc_out;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, acc_out
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, acc_out
    );
endinterface

// File: rtl/pipelined_arith_acc.sv
// Two-stage valid/ready add/sub/accumulate/clear unit with carry and overflow flags.
// Define SATURATE_EN to clamp results on carry/borrow instead of wrapping.
`timescale 1ns/1ps
module pipelined_arith_acc #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_arith_acc_if.slave bus
);
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11} op_e;

    logic             s1Valid_q, s1Valid_d;
    op_e              s1Op_q, s1Op_d;
    logic [WIDTH-1:0] s1A_q, s1A_d;
    logic [WIDTH-1:0] s1B_q, s1B_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2Adv;
    logic             accept;
    logic [WIDTH-1:0] lhs, rhs;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] resRaw, resFinal;
    logic             cFlag, vFlag;

    assign s2Adv        = !outValid_q || bus.out_ready;
    assign bus.in_ready = rst_n && (!s1Valid_q || s2Adv);
    assign accept       = bus.in_valid && bus.in_ready;

    // ACC reads the accumulator here in stage 2, so consecutive ACC beats chain without bubbles.
    always_comb begin
        lhs    = (s1Op_q == OP_ACC) ? acc_q : s1A_q;
        rhs    = (s1Op_q == OP_ACC) ? s1A_q : s1B_q;
        sum    = {1'b0, lhs} + {1'b0, rhs};
        diff   = {1'b0, lhs} - {1'b0, rhs};
        resRaw = '0;
        cFlag  = 1'b0;
        vFlag  = 1'b0;
        case (s1Op_q)
            OP_ADD, OP_ACC: begin
                resRaw = sum[WIDTH-1:0];
                cFlag  = sum[WIDTH];
                vFlag  = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);
            end
            OP_SUB: begin
                resRaw = diff[WIDTH-1:0];
                cFlag  = diff[WIDTH];
                vFlag  = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (diff[WIDTH-1] != lhs[WIDTH-1]);
            end
            default: begin
                resRaw = '0;
                cFlag  = 1'b0;
                vFlag  = 1'b0;
            end
        endcase
`ifdef SATURATE_EN
        if (cFlag)
            resFinal = (s1Op_q == OP_SUB) ? '0 : '1;
        else
            resFinal = resRaw;
`else
        resFinal = resRaw;
`endif
    end

    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1Op_d     = s1Op_q;
        s1A_d      = s1A_q;
        s1B_d      = s1B_q;
        outValid_d = outValid_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        acc_d      = acc_q;

        if (accept) begin
            s1Valid_d = 1'b1;
            s1Op_d    = op_e'(bus.op);
            s1A_d     = bus.a;
            s1B_d     = bus.b;
        end else if (s1Valid_q && s2Adv) begin
            s1Valid_d = 1'b0;
        end

        // Stage 2 only moves when the consumer has room; otherwise every output holds.
        if (s2Adv) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                result_d   = resFinal;
                carry_d    = cFlag;
                overflow_d = vFlag;
                if (s1Op_q == OP_ACC || s1Op_q == OP_CLR)
                    acc_d = resFinal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Op_q     <= OP_ADD;
            s1A_q      <= '0;
            s1B_q      <= '0;
            outValid_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Op_q     <= s1Op_d;
            s1A_q      <= s1A_d;
            s1B_q      <= s1B_d;
            outValid_q <= outValid_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.acc_out   = acc_q;
endmodule

// File: tb/tb_pipelined_arith_acc.sv
// Scoreboard bench for pipelined_arith_acc (WIDTH=8); follows SATURATE_EN if defined.
`timescale 1ns/1ps
module tb_pipelined_arith_acc;
    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       overflow;
        logic [7:0] acc;
    } expT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   testsRun = 0;
    int   failCount = 0;
    expT  sbQ[$];
    logic [7:0] modelAcc = 8'd0;

    pipelined_arith_acc_if #(.WIDTH(8)) bus();

    pipelined_arith_acc #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference arithmetic in plain integers, independent of bit-slicing tricks.
    function automatic expT model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] acc);
        expT e;
        int  ua, ub, sa, sb, s, sr;
        e  = '0;
        ua = (op == 2'b10) ? int'(acc) : int'(a);
        ub = (op == 2'b10) ? int'(a) : int'(b);
        sa = (op == 2'b10) ? int'($signed(acc)) : int'($signed(a));
        sb = (op == 2'b10) ? int'($signed(a)) : int'($signed(b));
        e.acc = acc;
        case (op)
            2'b00, 2'b10: begin
                s  = ua + ub;
                sr = sa + sb;
                e.carry    = (s > 255);
                e.overflow = (sr > 127) || (sr < -128);
                e.result   = 8'(s);
`ifdef SATURATE_EN
                if (e.carry) e.result = 8'd255;
`endif
                if (op == 2'b10) e.acc = e.result;
            end
            2'b01: begin
                s  = ua - ub;
                sr = sa - sb;
                e.carry    = (ua < ub);
                e.overflow = (sr > 127) || (sr < -128);
                e.result   = 8'(s);
`ifdef SATURATE_EN
                if (e.carry) e.result = 8'd0;
`endif
            end
            default: begin
                e.result = 8'd0;
                e.acc    = 8'd0;
            end
        endcase
        return e;
    endfunction

    // Handshakes are sampled mid-cycle, where they reflect what the next rising edge will do.
    always @(negedge clk) begin
        expT e;
        if (!rst_n) begin
            sbQ.delete();
            modelAcc = 8'd0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                testsRun++;
                if (sbQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL sb_unexpected got result %0d want no output", bus.result);
                end else begin
                    e = sbQ.pop_front();
                    if ({bus.result, bus.carry, bus.overflow, bus.acc_out} !== e) begin
                        failCount++;
                        $display("[TB] FAIL sb_beat got r=%0d c=%0d v=%0d acc=%0d want r=%0d c=%0d v=%0d acc=%0d",
                                 bus.result, bus.carry, bus.overflow, bus.acc_out,
                                 e.result, e.carry, e.overflow, e.acc);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.op, bus.a, bus.b, modelAcc);
                modelAcc = e.acc;
                sbQ.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 2'b00;
        bus.a = 8'd0;
        bus.b = 8'd0;
        tick();
        tick();
        @(negedge clk);
        testsRun++;
        if (bus.in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_in_ready got %b want 0", bus.in_ready);
        end
        testsRun++;
        if ({bus.out_valid, bus.result, bus.carry, bus.overflow, bus.acc_out} !== 19'd0) begin
            failCount++;
            $display("[TB] FAIL rst_outputs got v=%b r=%0d c=%b o=%b acc=%0d want all 0",
                     bus.out_valid, bus.result, bus.carry, bus.overflow, bus.acc_out);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if (bus.in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL rst_release_ready got %b want 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_add_latency();
        logic [7:0] want;
`ifdef SATURATE_EN
        want = 8'd255;
`else
        want = 8'd44;
`endif
        bus.in_valid = 1'b1; bus.op = 2'b00; bus.a = 8'd200; bus.b = 8'd100;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL add_early_valid got %b want 0", bus.out_valid);
        end
        tick();
        @(negedge clk);
        testsRun++;
        if ({bus.out_valid, bus.result, bus.carry, bus.overflow} !== {1'b1, want, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL add_latency got v=%b r=%0d c=%b o=%b want v=1 r=%0d c=1 o=0",
                     bus.out_valid, bus.result, bus.carry, bus.overflow, want);
        end
        idle(3);
    endtask

    task automatic test_flags();
        logic [7:0] wantSub;
`ifdef SATURATE_EN
        wantSub = 8'd0;
`else
        wantSub = 8'd251;
`endif
        bus.in_valid = 1'b1; bus.op = 2'b00; bus.a = 8'd100; bus.b = 8'd100;
        tick();
        bus.op = 2'b01; bus.a = 8'd5; bus.b = 8'd10;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({bus.out_valid, bus.result, bus.carry, bus.overflow} !== {1'b1, 8'd200, 1'b0, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL add_overflow got v=%b r=%0d c=%b o=%b want v=1 r=200 c=0 o=1",
                     bus.out_valid, bus.result, bus.carry, bus.overflow);
        end
        tick();
        @(negedge clk);
        testsRun++;
        if ({bus.out_valid, bus.result, bus.carry, bus.overflow} !== {1'b1, wantSub, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL sub_borrow got v=%b r=%0d c=%b o=%b want v=1 r=%0d c=1 o=0",
                     bus.out_valid, bus.result, bus.carry, bus.overflow, wantSub);
        end
        idle(3);
    endtask

    task automatic test_accumulate();
        logic [7:0] ops [4];
        logic [7:0] vals [4];
        logic [7:0] want [4];
        ops  = '{8'd3, 8'd2, 8'd2, 8'd2};
        vals = '{8'd0, 8'd10, 8'd20, 8'd30};
        want = '{8'd0, 8'd10, 8'd30, 8'd60};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1; bus.op = ops[i][1:0]; bus.a = vals[i]; bus.b = 8'd99;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 2) begin
                testsRun++;
                if ({bus.out_valid, bus.result} !== {1'b1, want[i-2]}) begin
                    failCount++;
                    $display("[TB] FAIL acc_chain[%0d] got v=%b r=%0d want v=1 r=%0d",
                             i - 2, bus.out_valid, bus.result, want[i-2]);
                end
            end
            tick();
        end
        @(negedge clk);
        testsRun++;
        if (bus.acc_out !== 8'd60) begin
            failCount++;
            $display("[TB] FAIL acc_final got %0d want 60", bus.acc_out);
        end
        idle(3);
    endtask

    task automatic test_backpressure();
        logic [7:0] got [$];
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.op = 2'b00;
            bus.a = (i > 3) ? 8'd3 : 8'(i); bus.b = bus.a;
            @(negedge clk);
            testsRun++;
            if (bus.in_ready !== (i <= 2)) begin
                failCount++;
                $display("[TB] FAIL bp_in_ready[%0d] got %b want %b", i, bus.in_ready, (i <= 2));
            end
            if (i == 4) begin
                testsRun++;
                if ({bus.out_valid, bus.result} !== {1'b1, 8'd2}) begin
                    failCount++;
                    $display("[TB] FAIL bp_hold got v=%b r=%0d want v=1 r=2", bus.out_valid, bus.result);
                end
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 0) begin
                testsRun++;
                if (bus.in_ready !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL bp_release_ready got %b want 1", bus.in_ready);
                end
            end
            if (bus.out_valid) got.push_back(bus.result);
            tick();
            if (n == 0) bus.in_valid = 1'b0;
        end
        testsRun++;
        if (got.size() != 3 || got[0] !== 8'd2 || got[1] !== 8'd4 || got[2] !== 8'd6) begin
            failCount++;
            $display("[TB] FAIL bp_order got %0d beats (first %0d) want 3 beats 2,4,6",
                     got.size(), (got.size() > 0) ? got[0] : 8'd0);
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.op = 2'b11; bus.a = 8'd0; bus.b = 8'd0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.op = 2'b10; bus.a = 8'd5;
            tick();
        end
        idle(3);
        @(negedge clk);
        testsRun++;
        if (bus.acc_out !== 8'd40) begin
            failCount++;
            $display("[TB] FAIL mid_acc_pre got %0d want 40", bus.acc_out);
        end
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b1; bus.op = 2'b10; bus.a = 8'd5;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL mid_full got ready=%b valid=%b want ready=0 valid=1",
                     bus.in_ready, bus.out_valid);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.carry, bus.overflow, bus.acc_out} !== 20'h80000) begin
            failCount++;
            $display("[TB] FAIL mid_reset got ready=%b v=%b r=%0d c=%b o=%b acc=%0d want ready=1 rest 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.carry, bus.overflow, bus.acc_out);
        end
        bus.out_ready = 1'b1;
        idle(3);
    endtask

    task automatic test_random();
        int guard;
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.op        = 2'($urandom_range(0, 3));
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (sbQ.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        testsRun++;
        if (sbQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL rand_drain got %0d pending beats want 0", sbQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_flags();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
